ultrasonic_echo_emulator: RTL and testbench
===========================================

# ultrasonic_echo_emulator

Responder end of the HC-SR04 style ultrasonic ranging interface. It accepts a trigger pulse from a sensor driver and returns an echo pulse whose width encodes a programmed distance in centimetres. It sits in the test and demo fabric in place of a physical sensor, so the ranging driver can be exercised in simulation and on the board without hardware. Timing defaults assume a 100 MHz clock (10 ns period).

## Interface
- `TRIG_MIN`, 1000: minimum trigger high width in cycles (10 µs) for the trigger to be accepted.
- `BURST_DLY`, 20000: cycles from trigger acceptance to echo rise (200 µs, emulates the 8-cycle 40 kHz burst).
- `CYC_PER_CM`, 5800: echo cycles per centimetre (58 µs/cm).
- `MAX_CM`, 400: largest in-range distance.
- `TIMEOUT`, 3800000: echo width for an out-of-range distance (38 ms).
- `HOLDOFF`, 6000000: dead time after echo fall before a new trigger is armed (60 ms).
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-low reset (0 = reset).
- `trigger`  input  1  asynchronous trigger from the driver.
- `distance_cm`  input  16  distance to report; sampled once per measurement.
- `echo`  output  1  echo pulse, registered.
- `busy`  output  1  high in every state except IDLE and TRIG_HI.
- `meas_done`  output  1  one-cycle pulse on the cycle echo falls.
- `short_trig`  output  1  one-cycle pulse when a trigger shorter than `TRIG_MIN` is rejected.

## Operation
- `trigger` passes through a 2-flop synchronizer. Rising and falling edges are detected on the synchronized value `trig_s`.
- FSM states:
  - **IDLE:** on a `trig_s` rise, go to TRIG_HI and clear the width counter.
  - **TRIG_HI:** count cycles while `trig_s` = 1 (the counter saturates at `TRIG_MIN`). When `trig_s` falls:
    - If count ≥ `TRIG_MIN`, latch `distance_cm` and go to BURST.
    - Otherwise pulse `short_trig` and return to IDLE.
  - **BURST:** count `BURST_DLY` cycles, then go to ECHO.
  - **ECHO:** `echo` = 1 for exactly W cycles, then pulse `meas_done` and go to HOLDOFF.
  - **HOLDOFF:** count `HOLDOFF` cycles, then go to IDLE.
- Echo width W:
  - If the latched d is in 1..`MAX_CM`, W = d × `CYC_PER_CM`. Use a 32-bit unsigned product, computed once when d is latched.
  - If d = 0 or d > `MAX_CM`, W = `TIMEOUT`.
- `trigger` activity in BURST, ECHO or HOLDOFF is ignored. Edges are not queued. A trigger still high when IDLE is entered is not accepted until it falls and rises again.
- `distance_cm` changes after the latch have no effect on the measurement in progress.
- All counters are 32 bits wide and count down to zero. There is no wrap-around.

## Timing
- Reset values: `echo`, `busy`, `meas_done` and `short_trig` are 0, the FSM is in IDLE, and all counters are 0.
- Reset asserted mid-operation forces `echo` low asynchronously. The measurement is discarded and no `meas_done` is produced.
- Synchronizer latency is 2 cycles on both trigger edges.
- Define t0 as the clock edge at which TRIG_HI observes `trig_s` = 0 with an accepted width. Then:
  - `busy` rises at t0.
  - `echo` rises at t0 + `BURST_DLY`.
  - `echo` falls at t0 + `BURST_DLY` + W.
  - `meas_done` is high for the single cycle in which `echo` first reads 0.
  - Re-arm happens at echo fall + `HOLDOFF`.
- Width boundary: a trigger high for exactly `TRIG_MIN` synchronized cycles is accepted; `TRIG_MIN` − 1 is rejected.
- A trigger rising in the same cycle the FSM enters IDLE is not seen. Only a rise observed while in IDLE counts.

## Structure
- Package `ultrasonic_pkg` holds:
  - the FSM state enum (IDLE, TRIG_HI, BURST, ECHO, HOLDOFF);
  - the default timing constants, shared with the ranging driver;
  - the 32-bit counter width constant.
- One sub-module, `ultrasonic_sync`, provides the 2-flop synchronizer with edge-detect outputs. It also uses the active-low asynchronous `reset`.

## Test plan
Scaled parameters for all scenarios: `TRIG_MIN`=10, `BURST_DLY`=20, `CYC_PER_CM`=58, `MAX_CM`=400, `TIMEOUT`=1000, `HOLDOFF`=100.

- **Nominal:** `distance_cm`=17, trigger high 12 cycles → `echo` rises 20 cycles after t0 and stays high 986 cycles; one `meas_done`; `busy` falls 100 cycles after echo falls.
- **Width boundary:** trigger high 9 cycles → `short_trig` pulse, `echo` stays 0. Trigger high exactly 10 cycles → accepted.
- **Out of range:** `distance_cm`=0, then 401, then 400 → widths 1000, 1000 and 23200 cycles respectively.
- **Ignored trigger:** extra trigger pulses during BURST, ECHO and HOLDOFF → no change to echo timing or width; no extra `meas_done`.
- **Distance stability:** `distance_cm` changes from 17 to 5 during ECHO → width stays 986; the next measurement gives 290.
- **Reset mid-echo:** `reset`=0 partway through ECHO → `echo` is 0 immediately, no `meas_done`; after release, a new 12-cycle trigger gives normal timing.

Source files
------------

// File: rtl/ultrasonic_pkg.sv
// Shared definitions for the ultrasonic ranging emulator and its driver.
package ultrasonic_pkg;

  localparam int unsigned CNT_W = 32;

  // Defaults for a 100 MHz clock.
  localparam int unsigned TRIG_MIN_DEF   = 1000;
  localparam int unsigned BURST_DLY_DEF  = 20000;
  localparam int unsigned CYC_PER_CM_DEF = 5800;
  localparam int unsigned MAX_CM_DEF     = 400;
  localparam int unsigned TIMEOUT_DEF    = 3800000;
  localparam int unsigned HOLDOFF_DEF    = 6000000;

  typedef enum logic [2:0] {
    StIdle,
    StTrigHi,
    StBurst,
    StEcho,
    StHoldoff
  } state_e;

  // Echo width in cycles for a distance; out-of-range distances report the timeout width.
  function automatic logic [CNT_W-1:0] echo_width(input logic [15:0]   d,
                                                  input int unsigned   cyc_per_cm,
                                                  input int unsigned   max_cm,
                                                  input int unsigned   timeout);
    if (d == 16'd0 || 32'(d) > max_cm) begin
      return timeout;
    end
    return 32'(d) * cyc_per_cm;
  endfunction

endpackage

// File: rtl/ultrasonic_sync.sv
// Two-flop synchronizer for the trigger input with edge detection on the synced value.
module ultrasonic_sync (
  input  logic clk,
  input  logic reset,
  input  logic trigger,
  output logic trig_s,
  output logic trig_rise,
  output logic trig_fall
);

  logic meta_q, sync_q, prev_q;

  // Shift the raw trigger through two metastability flops, then keep one delayed copy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= trigger;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign trig_s    = sync_q;
  assign trig_rise = sync_q & ~prev_q;
  assign trig_fall = ~sync_q & prev_q;

endmodule

// File: rtl/ultrasonic_echo_emulator.sv
// HC-SR04 style responder: accepts a trigger pulse and returns an echo whose width
// encodes the programmed distance.
module ultrasonic_echo_emulator
  import ultrasonic_pkg::*;
#(
  parameter int unsigned TRIG_MIN   = TRIG_MIN_DEF,
  parameter int unsigned BURST_DLY  = BURST_DLY_DEF,
  parameter int unsigned CYC_PER_CM = CYC_PER_CM_DEF,
  parameter int unsigned MAX_CM     = MAX_CM_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
  parameter int unsigned HOLDOFF    = HOLDOFF_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic [15:0] distance_cm,
  output logic        echo,
  output logic        busy,
  output logic        meas_done,
  output logic        short_trig
);

  logic trig_s, trig_rise, trig_fall;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] width_q;

  ultrasonic_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .trigger   (trigger),
    .trig_s    (trig_s),
    .trig_rise (trig_rise),
    .trig_fall (trig_fall)
  );

  // Measurement FSM with registered outputs; pulse outputs default low every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      width_q    <= '0;
      echo       <= 1'b0;
      busy       <= 1'b0;
      meas_done  <= 1'b0;
      short_trig <= 1'b0;
    end else begin
      meas_done  <= 1'b0;
      short_trig <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // The cycle the rise is observed is already the first high cycle of the pulse.
          if (trig_rise) begin
            cnt_q   <= 32'd1;
            state_q <= StTrigHi;
          end
        end
        StTrigHi: begin
          if (trig_fall) begin
            if (cnt_q >= TRIG_MIN) begin
              // Width is fixed here, so later distance changes cannot affect this echo.
              width_q <= echo_width(distance_cm, CYC_PER_CM, MAX_CM, TIMEOUT);
              cnt_q   <= BURST_DLY;
              busy    <= 1'b1;
              state_q <= StBurst;
            end else begin
              short_trig <= 1'b1;
              cnt_q      <= '0;
              state_q    <= StIdle;
            end
          end else if (trig_s && cnt_q < TRIG_MIN) begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StBurst: begin
          if (cnt_q <= 32'd1) begin
            echo    <= 1'b1;
            cnt_q   <= width_q;
            state_q <= StEcho;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        StEcho: begin
          if (cnt_q <= 32'd1) begin
            echo      <= 1'b0;
            meas_done <= 1'b1;
            cnt_q     <= HOLDOFF;
            state_q   <= StHoldoff;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        StHoldoff: begin
          // A rise coinciding with this exit is consumed here and never reaches IDLE.
          if (cnt_q <= 32'd1) begin
            busy    <= 1'b0;
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Directed bench for ultrasonic_echo_emulator using scaled timing parameters.
module tb_ultrasonic_echo_emulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        trigger;
  logic [15:0] distance_cm;
  logic        echo, busy, meas_done, short_trig;

  int total = 0;
  int bad   = 0;

  int t_busy, t_echo, w, t_idle, md_cnt, md_fall;
  int st_cnt, st_at, echo_seen, busy_seen;

  always #5 clk = ~clk;

  ultrasonic_echo_emulator #(
    .TRIG_MIN   (10),
    .BURST_DLY  (20),
    .CYC_PER_CM (58),
    .MAX_CM     (400),
    .TIMEOUT    (1000),
    .HOLDOFF    (100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .trigger     (trigger),
    .distance_cm (distance_cm),
    .echo        (echo),
    .busy        (busy),
    .meas_done   (meas_done),
    .short_trig  (short_trig)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Trigger high across exactly n rising edges, then time the whole measurement.
  // t_busy counts negedges after release; t_echo counts from the busy negedge;
  // w counts echo-high negedges; t_idle counts from the first echo-low negedge.
  task automatic run_meas(input int n, input bit noise, input int chg_at,
                          input logic [15:0] chg_val,
                          output int tb_o, output int te_o, output int w_o,
                          output int ti_o, output int md_o, output int mf_o);
    int c;
    md_o = 0;
    mf_o = 0;
    @(negedge clk) trigger = 1'b1;
    repeat (n) @(negedge clk);
    trigger = 1'b0;
    tb_o = -1;
    for (c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (meas_done) md_o++;
      if (busy) begin
        tb_o = c;
        break;
      end
    end
    te_o = -1;
    for (c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (meas_done) md_o++;
      if (echo) begin
        te_o = c;
        break;
      end
      if (noise && c == 5) trigger = 1'b1;
      if (noise && c == 10) trigger = 1'b0;
    end
    w_o = 1;
    for (c = 0; c < 30000; c++) begin
      @(negedge clk);
      if (meas_done) md_o++;
      if (!echo) begin
        mf_o = int'(meas_done);
        break;
      end
      w_o++;
      if (chg_at != 0 && w_o == chg_at) distance_cm = chg_val;
      if (noise && w_o == 100) trigger = 1'b1;
      if (noise && w_o == 120) trigger = 1'b0;
    end
    ti_o = -1;
    for (c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (meas_done) md_o++;
      if (!busy) begin
        ti_o = c;
        break;
      end
      if (noise && c == 30) trigger = 1'b1;
      if (noise && c == 50) trigger = 1'b0;
    end
  endtask

  initial begin
    reset       = 1'b0;
    trigger     = 1'b0;
    distance_cm = 16'd17;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_echo", int'(echo), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_meas_done", int'(meas_done), 0);
    chk("rst_short_trig", int'(short_trig), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Nominal: 17 cm -> 986 cycles.
    run_meas(12, 1'b0, 0, 16'd0, t_busy, t_echo, w, t_idle, md_cnt, md_fall);
    chk("nom_busy_rise", t_busy, 3);
    chk("nom_echo_rise", t_echo, 20);
    chk("nom_width", w, 986);
    chk("nom_md_at_fall", md_fall, 1);
    chk("nom_md_count", md_cnt, 1);
    chk("nom_rearm", t_idle, 100);

    // Width boundary: 9 cycles rejected.
    @(negedge clk) trigger = 1'b1;
    repeat (9) @(negedge clk);
    trigger   = 1'b0;
    st_cnt    = 0;
    st_at     = -1;
    echo_seen = 0;
    busy_seen = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (short_trig) begin
        st_cnt++;
        if (st_at < 0) st_at = c;
      end
      if (echo) echo_seen++;
      if (busy) busy_seen++;
    end
    chk("short_count", st_cnt, 1);
    chk("short_at", st_at, 3);
    chk("short_no_echo", echo_seen, 0);
    chk("short_no_busy", busy_seen, 0);

    // Width boundary: exactly 10 cycles accepted.
    run_meas(10, 1'b0, 0, 16'd0, t_busy, t_echo, w, t_idle, md_cnt, md_fall);
    chk("min_busy_rise", t_busy, 3);
    chk("min_width", w, 986);

    // Out of range and upper bound.
    distance_cm = 16'd0;
    run_meas(12, 1'b0, 0, 16'd0, t_busy, t_echo, w, t_idle, md_cnt, md_fall);
    chk("d0_width", w, 1000);
    chk("d0_md_count", md_cnt, 1);
    distance_cm = 16'd401;
    run_meas(12, 1'b0, 0, 16'd0, t_busy, t_echo, w, t_idle, md_cnt, md_fall);
    chk("d401_width", w, 1000);
    distance_cm = 16'd400;
    run_meas(12, 1'b0, 0, 16'd0, t_busy, t_echo, w, t_idle, md_cnt, md_fall);
    chk("d400_width", w, 23200);
    chk("d400_rearm", t_idle, 100);

    // Ignored triggers during BURST, ECHO and HOLDOFF.
    distance_cm = 16'd17;
    run_meas(12, 1'b1, 0, 16'd0, t_busy, t_echo, w, t_idle, md_cnt, md_fall);
    chk("noise_echo_rise", t_echo, 20);
    chk("noise_width", w, 986);
    chk("noise_md_count", md_cnt, 1);
    chk("noise_rearm", t_idle, 100);
    // The holdoff pulse must not have left a pending measurement.
    busy_seen = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    chk("noise_no_retrigger", busy_seen, 0);

    // Distance change during ECHO does not affect the current echo.
    run_meas(12, 1'b0, 50, 16'd5, t_busy, t_echo, w, t_idle, md_cnt, md_fall);
    chk("stable_width", w, 986);
    run_meas(12, 1'b0, 0, 16'd0, t_busy, t_echo, w, t_idle, md_cnt, md_fall);
    chk("next_width_5cm", w, 290);

    // Reset in the middle of ECHO.
    distance_cm = 16'd17;
    @(negedge clk) trigger = 1'b1;
    repeat (12) @(negedge clk);
    trigger   = 1'b0;
    echo_seen = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (echo) begin
        echo_seen = 1;
        break;
      end
    end
    chk("rst_mid_echo_reached", echo_seen, 1);
    repeat (30) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_echo_low", int'(echo), 0);
    chk("rst_mid_busy_low", int'(busy), 0);
    md_cnt = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (meas_done) md_cnt++;
    end
    reset = 1'b1;
    for (int c = 1; c <= 1100; c++) begin
      @(negedge clk);
      if (meas_done) md_cnt++;
    end
    chk("rst_mid_no_md", md_cnt, 0);
    run_meas(12, 1'b0, 0, 16'd0, t_busy, t_echo, w, t_idle, md_cnt, md_fall);
    chk("post_rst_busy_rise", t_busy, 3);
    chk("post_rst_echo_rise", t_echo, 20);
    chk("post_rst_width", w, 986);
    chk("post_rst_md_count", md_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
